mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle successor to the single-cycle MIPS main/ALU decoder pair.
- One Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory.
- Adds a counted multi-cycle mult/div sequence that writes HI/LO, plus dedicated mfhi/mflo writeback.
- Sits between the instruction register (op/funct) and the multicycle datapath.

Parameters:
- MULT_LAT, 4: cycles spent in the MULDIV state for mult (≥1).
- DIV_LAT, 32: cycles spent in the MULDIV state for div (≥1).
- CNT_W, 6: down-counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low.
- op  in  6  instruction[31:26] from the instruction register.
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- pcen  out  1  PC write enable = pcwrite | (branch & zero).
- iord  out  1  memory address select: 0 PC, 1 ALUOut.
- irwrite  out  1  instruction register load.
- memwrite  out  1  data memory write.
- lb  out  1  byte load with sign-extend.
- regwrite  out  1  register file write.
- regdst  out  2  write register select: 00 rt, 01 rd, 10 $31.
- memtoreg  out  2  writeback source: 00 ALUOut, 01 MDR, 10 PC, 11 HI/LO.
- alusrca  out  1  ALU A select: 0 PC, 1 rs.
- alusrcb  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- pcsrc  out  2  next-PC select: 00 ALU, 01 ALUOut, 10 jump target, 11 rs.
- alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- shift  out  2  shifter select: 00 none, 01 sll, 10 srl.
- muldiv_start  out  1  one-cycle pulse that starts the multiplier/divider.
- muldiv_div  out  1  operation select: 1 div, 0 mult; valid while busy.
- hilo_we  out  1  HI/LO register write.
- hisel  out  1  HI/LO read select: 1 HI (mfhi), 0 LO (mflo).
- busy  out  1  high throughout the MULDIV state.
- illegal  out  1  one-cycle flag for an undecodable instruction.

Behaviour:
- Reset: reset==0 at a clock edge sets state to FETCH and the counter to 0. While reset==0, every output is forced to 0.
- Outputs are a Moore decode of the state register only; there are no output registers. The exceptions are pcen, which uses zero in BRANCH, and the muldiv_start/hilo_we counter conditions.
- Any control signal not listed for a state is 0.
- FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, pcen=1. Next state: DECODE.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target computed into ALUOut). Next state by op:
  - 100011 lw, 100000 lb, 101011 sw → MEMADR.
  - 000000 → RTYPEEX, except funct 011000/011010 → MULDIV, funct 010000/010010 → MFWB, funct 001000 → JR.
  - 000100 → BRANCH.
  - 001000 → ADDIEX.
  - 000010 → JUMP.
  - 000011 → JAL.
  - Anything else, or an R-type funct outside {add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, srl 000010, mult, div, mfhi, mflo, jr}, → FETCH with illegal=1 for that DECODE cycle and no writes.
- MEMADR: alusrca=1, alusrcb=10, alucontrol=010. Next: MEMRD for lw/lb, MEMWR for sw.
- MEMRD: iord=1; lb=1 if op==100000. Next: MEMWB.
- MEMWB: regdst=00, memtoreg=01, regwrite=1; lb held as in MEMRD. Next: FETCH.
- MEMWR: iord=1, memwrite=1. Next: FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct (sub→110, and→000, or→001, slt→111, else 010). shift=01 for sll, 10 for srl. Next: ALUWB.
- ALUWB: regdst=01, memtoreg=00, regwrite=1; shift held as in RTYPEEX. Next: FETCH.
  - funct 000000 with all other bits zero (nop) writes $0, which is harmless.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01; pcen=zero. Next: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alucontrol=010. Next: ADDIWB.
- ADDIWB: regdst=00, memtoreg=00, regwrite=1. Next: FETCH.
- JUMP: pcsrc=10, pcen=1. Next: FETCH.
- JAL: regdst=10, memtoreg=10, regwrite=1, pcsrc=10, pcen=1. PC already holds PC+4. Next: FETCH.
- JR: pcsrc=11, pcen=1. Next: FETCH.
- MULDIV:
  - On entry the counter loads LAT-1, where LAT is DIV_LAT if funct==011010, else MULT_LAT.
  - busy=1 throughout; muldiv_div=funct[1].
  - muldiv_start=1 only in the entry cycle (counter==LAT-1).
  - Counter decrements each cycle; hilo_we=1 when counter==0, then next state is FETCH.
  - LAT=1: start and hilo_we assert in the same single cycle.
  - Total cycles in MULDIV is exactly LAT. op/funct are assumed stable (IR not written).
- MFWB: regdst=01, memtoreg=11, hisel=(funct==010000), regwrite=1. Next: FETCH.
- Reset low mid-MULDIV: the state returns to FETCH next edge, the counter clears, and no hilo_we is issued.

Optional Feature:
- Macro: MC_CONTROLLER_STATE_OUT_EN.
- Defined: adds output port state_o (4 bits) carrying the state encoding. Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, JAL=12, JR=13, MULDIV=14, MFWB=15. state_o reads 0 in reset.
- Undefined: the port is absent; behaviour is otherwise identical.

Test Plan:
- Reset and fetch: hold reset=0 for 2 cycles → all outputs 0. Release reset → FETCH with pcen=1, irwrite=1, alusrcb=01.
- lw timing: op=100011 → FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH, 5 cycles. In MEMWB regwrite=1, memtoreg=01, lb=0. With op=100000, lb=1 in MEMRD and MEMWB.
- beq: op=000100 with zero=1 → pcen=1, pcsrc=01 in BRANCH. With zero=0 → pcen=0. Both take 3 cycles total.
- div: op=0, funct=011010, DIV_LAT=32 → muldiv_start for 1 cycle, busy for 32 cycles, hilo_we only in the 32nd, back to FETCH. mult takes 4 cycles.
- Illegal and mfhi: op=111111 → illegal=1 in DECODE, no regwrite/memwrite, back to FETCH. funct=010000 → MFWB with hisel=1, memtoreg=11, regwrite=1.
- Reset mid-MULDIV: reset=0 at cycle 10 of a div → FETCH next cycle, busy=0, hilo_we never asserted.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS controller: one Moore FSM over fetch/decode/execute/mem/writeback plus counted mult/div.
// Optional state_o debug port enabled by MC_CONTROLLER_STATE_OUT_EN.
module mc_controller #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       lb,
    output logic       regwrite,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [1:0] shift,
    output logic       muldiv_start,
    output logic       muldiv_div,
    output logic       hilo_we,
    output logic       hisel,
    output logic       busy,
    output logic       illegal
`ifdef MC_CONTROLLER_STATE_OUT_EN
    ,
    output logic [3:0] state_o
`endif
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_RTYPEEX = 4'd6, S_ALUWB  = 4'd7,
        S_BRANCH  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
        S_JAL     = 4'd12, S_JR     = 4'd13, S_MULDIV = 4'd14, S_MFWB   = 4'd15
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_LAT - 1);

    state_t           state_q, state_d;
    state_t           dec_nxt;
    logic             dec_ill;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_m1;

    assign lat_m1 = (funct == 6'b011010) ? DIV_LAST : MULT_LAST;

    // Dispatch out of DECODE; anything undecodable falls back to FETCH flagged illegal.
    always_comb begin
        dec_nxt = S_FETCH;
        dec_ill = 1'b0;
        case (op)
            6'b100011, 6'b100000, 6'b101011: dec_nxt = S_MEMADR;
            6'b000100:                       dec_nxt = S_BRANCH;
            6'b001000:                       dec_nxt = S_ADDIEX;
            6'b000010:                       dec_nxt = S_JUMP;
            6'b000011:                       dec_nxt = S_JAL;
            6'b000000: begin
                case (funct)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101,
                    6'b101010, 6'b000000, 6'b000010: dec_nxt = S_RTYPEEX;
                    6'b011000, 6'b011010:            dec_nxt = S_MULDIV;
                    6'b010000, 6'b010010:            dec_nxt = S_MFWB;
                    6'b001000:                       dec_nxt = S_JR;
                    default:                         dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pcen         = 1'b0;
        iord         = 1'b0;
        irwrite      = 1'b0;
        memwrite     = 1'b0;
        lb           = 1'b0;
        regwrite     = 1'b0;
        regdst       = 2'b00;
        memtoreg     = 2'b00;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        alucontrol   = 3'b000;
        shift        = 2'b00;
        muldiv_start = 1'b0;
        muldiv_div   = 1'b0;
        hilo_we      = 1'b0;
        hisel        = 1'b0;
        busy         = 1'b0;
        illegal      = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    irwrite = 1'b1; alusrcb = 2'b01; alucontrol = 3'b010; pcen = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    alusrcb = 2'b11; alucontrol = 3'b010;
                    illegal = dec_ill;
                    state_d = dec_nxt;
                    if (dec_nxt == S_MULDIV) cnt_d = lat_m1;
                end
                S_MEMADR: begin
                    alusrca = 1'b1; alusrcb = 2'b10; alucontrol = 3'b010;
                    state_d = (op == 6'b101011) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    iord = 1'b1; lb = (op == 6'b100000);
                    state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    memtoreg = 2'b01; regwrite = 1'b1; lb = (op == 6'b100000);
                    state_d = S_FETCH;
                end
                S_MEMWR: begin
                    iord = 1'b1; memwrite = 1'b1;
                    state_d = S_FETCH;
                end
                S_RTYPEEX: begin
                    alusrca = 1'b1;
                    case (funct)
                        6'b100010: alucontrol = 3'b110;
                        6'b100100: alucontrol = 3'b000;
                        6'b100101: alucontrol = 3'b001;
                        6'b101010: alucontrol = 3'b111;
                        default:   alucontrol = 3'b010;
                    endcase
                    shift   = (funct == 6'b000000) ? 2'b01 : (funct == 6'b000010) ? 2'b10 : 2'b00;
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    regdst = 2'b01; regwrite = 1'b1;
                    shift   = (funct == 6'b000000) ? 2'b01 : (funct == 6'b000010) ? 2'b10 : 2'b00;
                    state_d = S_FETCH;
                end
                S_BRANCH: begin
                    alusrca = 1'b1; alucontrol = 3'b110; pcsrc = 2'b01; pcen = zero;
                    state_d = S_FETCH;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1; alusrcb = 2'b10; alucontrol = 3'b010;
                    state_d = S_ADDIWB;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_JUMP: begin
                    pcsrc = 2'b10; pcen = 1'b1;
                    state_d = S_FETCH;
                end
                S_JAL: begin
                    regdst = 2'b10; memtoreg = 2'b10; regwrite = 1'b1; pcsrc = 2'b10; pcen = 1'b1;
                    state_d = S_FETCH;
                end
                S_JR: begin
                    pcsrc = 2'b11; pcen = 1'b1;
                    state_d = S_FETCH;
                end
                S_MULDIV: begin
                    // Counter runs LAT-1 down to 0; with LAT=1 start and hilo_we coincide.
                    busy         = 1'b1;
                    muldiv_div   = funct[1];
                    muldiv_start = (cnt_q == lat_m1);
                    if (cnt_q == '0) begin
                        hilo_we = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_MFWB: begin
                    regdst = 2'b01; memtoreg = 2'b11; regwrite = 1'b1;
                    hisel   = (funct == 6'b010000);
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MC_CONTROLLER_STATE_OUT_EN
    assign state_o = reset ? state_q : 4'd0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed table-driven bench for mc_controller: one record per clock cycle with hand-derived outputs.
module tb_mc_controller;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       lb;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic [1:0] shift;
        logic       muldiv_start;
        logic       muldiv_div;
        logic       hilo_we;
        logic       hisel;
        logic       busy;
        logic       illegal;
    } out_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        out_t       exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    out_t       got;
    int         n_checks = 0;
    int         n_pass = 0;
    vec_t       vecs[$];
    int         wait_cnt;
    int         busy_cnt;
    logic       saw_fetch;

    always #5 clk = ~clk;

`ifdef MC_CONTROLLER_STATE_OUT_EN
    logic [3:0] state_o;
`endif

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(got.pcen), .iord(got.iord), .irwrite(got.irwrite), .memwrite(got.memwrite),
        .lb(got.lb), .regwrite(got.regwrite), .regdst(got.regdst), .memtoreg(got.memtoreg),
        .alusrca(got.alusrca), .alusrcb(got.alusrcb), .pcsrc(got.pcsrc),
        .alucontrol(got.alucontrol), .shift(got.shift), .muldiv_start(got.muldiv_start),
        .muldiv_div(got.muldiv_div), .hilo_we(got.hilo_we), .hisel(got.hisel),
        .busy(got.busy), .illegal(got.illegal)
`ifdef MC_CONTROLLER_STATE_OUT_EN
        , .state_o(state_o)
`endif
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $finish;
    end

    // Expected output word per state, written straight from the state table.
    function automatic out_t e_fetch();
        out_t r = '0; r.irwrite = 1; r.alusrcb = 2'b01; r.alucontrol = 3'b010; r.pcen = 1; return r;
    endfunction
    function automatic out_t e_decode(input logic ill);
        out_t r = '0; r.alusrcb = 2'b11; r.alucontrol = 3'b010; r.illegal = ill; return r;
    endfunction
    function automatic out_t e_memadr();
        out_t r = '0; r.alusrca = 1; r.alusrcb = 2'b10; r.alucontrol = 3'b010; return r;
    endfunction
    function automatic out_t e_memrd(input logic b);
        out_t r = '0; r.iord = 1; r.lb = b; return r;
    endfunction
    function automatic out_t e_memwb(input logic b);
        out_t r = '0; r.memtoreg = 2'b01; r.regwrite = 1; r.lb = b; return r;
    endfunction
    function automatic out_t e_memwr();
        out_t r = '0; r.iord = 1; r.memwrite = 1; return r;
    endfunction
    function automatic out_t e_rtex(input logic [2:0] alu, input logic [1:0] sh);
        out_t r = '0; r.alusrca = 1; r.alucontrol = alu; r.shift = sh; return r;
    endfunction
    function automatic out_t e_aluwb(input logic [1:0] sh);
        out_t r = '0; r.regdst = 2'b01; r.regwrite = 1; r.shift = sh; return r;
    endfunction
    function automatic out_t e_branch(input logic z);
        out_t r = '0; r.alusrca = 1; r.alucontrol = 3'b110; r.pcsrc = 2'b01; r.pcen = z; return r;
    endfunction
    function automatic out_t e_addiwb();
        out_t r = '0; r.regwrite = 1; return r;
    endfunction
    function automatic out_t e_jump();
        out_t r = '0; r.pcsrc = 2'b10; r.pcen = 1; return r;
    endfunction
    function automatic out_t e_jal();
        out_t r = '0; r.regdst = 2'b10; r.memtoreg = 2'b10; r.regwrite = 1;
        r.pcsrc = 2'b10; r.pcen = 1; return r;
    endfunction
    function automatic out_t e_jr();
        out_t r = '0; r.pcsrc = 2'b11; r.pcen = 1; return r;
    endfunction
    function automatic out_t e_muldiv(input logic st, input logic dv, input logic we);
        out_t r = '0; r.busy = 1; r.muldiv_start = st; r.muldiv_div = dv; r.hilo_we = we; return r;
    endfunction
    function automatic out_t e_mfwb(input logic hi);
        out_t r = '0; r.regdst = 2'b01; r.memtoreg = 2'b11; r.regwrite = 1; r.hisel = hi; return r;
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input out_t e, input string n);
        vec_t v;
        v.rst_n = r; v.op = o; v.funct = f; v.zero = z; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic fd(input logic [5:0] o, input logic [5:0] f, input logic z, input string n);
        add(1, o, f, z, e_fetch(), {n, "_fetch"});
        add(1, o, f, z, e_decode(0), {n, "_decode"});
    endtask

    task automatic rtype(input logic [5:0] f, input logic [2:0] alu, input logic [1:0] sh,
                         input string n);
        fd(6'b000000, f, 0, n);
        add(1, 6'b000000, f, 0, e_rtex(alu, sh), {n, "_ex"});
        add(1, 6'b000000, f, 0, e_aluwb(sh), {n, "_wb"});
    endtask

    task automatic muldiv(input logic [5:0] f, input int lat, input string n);
        fd(6'b000000, f, 0, n);
        for (int k = 0; k < lat; k++)
            add(1, 6'b000000, f, 0, e_muldiv(k == 0, f[1], k == lat - 1), {n, "_busy"});
    endtask

    initial begin
        reset = 1'b0; op = '0; funct = '0; zero = 1'b0;

        add(0, 6'b100011, 6'b0, 1, out_t'('0), "reset0");
        add(0, 6'b100011, 6'b0, 1, out_t'('0), "reset1");

        fd(6'b100011, 6'b0, 0, "lw");
        add(1, 6'b100011, 6'b0, 0, e_memadr(), "lw_adr");
        add(1, 6'b100011, 6'b0, 0, e_memrd(0), "lw_rd");
        add(1, 6'b100011, 6'b0, 0, e_memwb(0), "lw_wb");

        fd(6'b100000, 6'b0, 0, "lb");
        add(1, 6'b100000, 6'b0, 0, e_memadr(), "lb_adr");
        add(1, 6'b100000, 6'b0, 0, e_memrd(1), "lb_rd");
        add(1, 6'b100000, 6'b0, 0, e_memwb(1), "lb_wb");

        fd(6'b101011, 6'b0, 0, "sw");
        add(1, 6'b101011, 6'b0, 0, e_memadr(), "sw_adr");
        add(1, 6'b101011, 6'b0, 0, e_memwr(), "sw_wr");

        fd(6'b000100, 6'b0, 1, "beq_t");
        add(1, 6'b000100, 6'b0, 1, e_branch(1), "beq_taken");
        fd(6'b000100, 6'b0, 0, "beq_n");
        add(1, 6'b000100, 6'b0, 0, e_branch(0), "beq_not");

        rtype(6'b100000, 3'b010, 2'b00, "add");
        rtype(6'b100010, 3'b110, 2'b00, "sub");
        rtype(6'b100100, 3'b000, 2'b00, "and");
        rtype(6'b100101, 3'b001, 2'b00, "or");
        rtype(6'b101010, 3'b111, 2'b00, "slt");
        rtype(6'b000000, 3'b010, 2'b01, "sll");
        rtype(6'b000010, 3'b010, 2'b10, "srl");

        fd(6'b001000, 6'b0, 0, "addi");
        add(1, 6'b001000, 6'b0, 0, e_memadr(), "addi_ex");
        add(1, 6'b001000, 6'b0, 0, e_addiwb(), "addi_wb");

        fd(6'b000010, 6'b0, 0, "j");
        add(1, 6'b000010, 6'b0, 0, e_jump(), "j_jump");
        fd(6'b000011, 6'b0, 0, "jal");
        add(1, 6'b000011, 6'b0, 0, e_jal(), "jal_jal");
        fd(6'b000000, 6'b001000, 0, "jr");
        add(1, 6'b000000, 6'b001000, 0, e_jr(), "jr_jr");

        add(1, 6'b111111, 6'b0, 0, e_fetch(), "illop_fetch");
        add(1, 6'b111111, 6'b0, 0, e_decode(1), "illop_decode");
        add(1, 6'b000000, 6'b000001, 0, e_fetch(), "illfn_fetch");
        add(1, 6'b000000, 6'b000001, 0, e_decode(1), "illfn_decode");

        fd(6'b000000, 6'b010000, 0, "mfhi");
        add(1, 6'b000000, 6'b010000, 0, e_mfwb(1), "mfhi_wb");
        fd(6'b000000, 6'b010010, 0, "mflo");
        add(1, 6'b000000, 6'b010010, 0, e_mfwb(0), "mflo_wb");

        muldiv(6'b011000, 4, "mult");
        muldiv(6'b011010, 32, "div");
        add(1, 6'b0, 6'b100000, 0, e_fetch(), "after_div_fetch");
        add(1, 6'b0, 6'b100000, 0, e_decode(0), "after_div_decode");
        add(1, 6'b0, 6'b100000, 0, e_rtex(3'b010, 2'b00), "after_div_ex");
        add(1, 6'b0, 6'b100000, 0, e_aluwb(2'b00), "after_div_wb");

        fd(6'b000000, 6'b011010, 0, "divrst");
        for (int k = 0; k < 9; k++)
            add(1, 6'b0, 6'b011010, 0, e_muldiv(k == 0, 1, 0), "divrst_busy");
        add(0, 6'b0, 6'b011010, 0, out_t'('0), "divrst_in_reset");
        add(1, 6'b0, 6'b011010, 0, e_fetch(), "divrst_fetch");
        add(1, 6'b0, 6'b011010, 0, e_decode(0), "divrst_decode");
        add(1, 6'b0, 6'b011010, 0, e_muldiv(1, 1, 0), "divrst_restart");

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst_n;
            op    = vecs[i].op;
            funct = vecs[i].funct;
            zero  = vecs[i].zero;
            @(negedge clk);
            n_checks++;
            if (!vecs[i].rst_n) begin
                if (got === out_t'('0)) n_pass++;
                else $display("FAIL reset-state %s (step %0d): got %h expected all zero",
                              vecs[i].name, i, got);
            end else begin
                if (got === vecs[i].exp) n_pass++;
                else $display("FAIL %s (step %0d): got %h expected %h",
                              vecs[i].name, i, got, vecs[i].exp);
            end
            @(posedge clk);
            #1;
        end

        // The restarted div is in progress; wait a bounded time for it to finish and return to FETCH.
        wait_cnt  = 0;
        busy_cnt  = 1;
        saw_fetch = 1'b0;
        while (!saw_fetch && wait_cnt < 40) begin
            @(negedge clk);
            if (got.irwrite) saw_fetch = 1'b1;
            else if (got.busy) busy_cnt++;
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        n_checks++;
        if (saw_fetch && busy_cnt == 32) n_pass++;
        else $display("FAIL expired wait: fetch seen=%0b after %0d cycles, busy cycles=%0d (expected 32)",
                      saw_fetch, wait_cnt, busy_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
